mem_access_ctrl: RTL and testbench

- Memory-stage access controller directly upstream of data_mem; the only driver of data_mem's address/writedata/memread/memwrite.
- Accepts byte-addressed load/store requests (byte, half, word; signed/unsigned loads) from the EX/MEM stage.
- Converts each request into word accesses on data_mem; sub-word stores use read-modify-write.
- Returns aligned, extended load data to writeback with a valid/ready handshake.

---
 rtl/mem_pkg.sv | 41 ++++
 rtl/mem_lane_align.sv | 60 ++++++
 rtl/mem_access_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory-stage access controller.
//   - access size codes as carried on the request size field
//   - byte lane select codes (little-endian, lane 0 = bits 7:0)
//   - controller FSM state type
//   - access_illegal(): alignment / size legality check done at accept
package mem_pkg;

  // Request size codes
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Byte lane selects, taken from addr[1:0]
  localparam logic [1:0] LANE_B0 = 2'b00;
  localparam logic [1:0] LANE_B1 = 2'b01;
  localparam logic [1:0] LANE_B2 = 2'b10;
  localparam logic [1:0] LANE_B3 = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWr,
    StRmwRd,
    StRmwWr,
    StDone
  } state_e;

  // True when the request must be rejected without touching memory
  function automatic logic access_illegal(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    unique case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != LANE_B0);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational lane steering for the access controller.
//   Load path : extracts the addressed byte/half/word from i_word and
//               zero- or sign-extends it into o_rdata.
//   Store path: replaces the addressed lane(s) of i_word with the low bits
//               of i_wdata, giving the word to write back (o_wword).
// Ports:
//   i_word   32  word read from data memory
//   i_wdata  32  right-justified store data
//   i_lane    2  byte address within the word (addr[1:0])
//   i_size    2  access size code
//   i_sext    1  sign-extend sub-word loads
//   o_rdata  32  extended load result (0 for an illegal size)
//   o_wword  32  merged store word
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_sext,
  output logic [31:0] o_rdata,
  output logic [31:0] o_wword
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    unique case (i_lane)
      LANE_B0: w_byte = i_word[7:0];
      LANE_B1: w_byte = i_word[15:8];
      LANE_B2: w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    // Halves are only ever addressed at lane 0 or lane 2
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_rdata = '0;
    case (i_size)
      SZ_BYTE: o_rdata = {{24{i_sext & w_byte[7]}}, w_byte};
      SZ_HALF: o_rdata = {{16{i_sext & w_half[15]}}, w_half};
      SZ_WORD: o_rdata = i_word;
      default: o_rdata = '0;
    endcase
  end

  always_comb begin
    o_wword = i_word;
    case (i_size)
      SZ_BYTE: o_wword[{i_lane, 3'b000} +: 8]     = i_wdata[7:0];
      SZ_HALF: o_wword[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
      SZ_WORD: o_wword = i_wdata;
      default: o_wword = i_word;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage load/store controller, sole driver of data_mem.
//   Accepts one byte-addressed request at a time (req && ready), turns it into
//   word accesses (read-modify-write for sb/sh) and reports completion with a
//   one-cycle done pulse carrying err and extended rdata.
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_req / o_ready       request handshake (ready only in idle)
//   i_we, i_size, i_sext  store flag, size code, sign-extend for loads
//   i_addr, i_wdata       byte address, right-justified store data
//   o_done, o_err, o_rdata  completion pulse, error flag, load result (held)
//   o_dm_*                data_mem word address, write data, read/write enables
//   i_dm_readdata         data_mem combinational read data
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req,
  output logic          o_ready,
  input  logic          i_we,
  input  logic [1:0]    i_size,
  input  logic          i_sext,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic          o_done,
  output logic          o_err,
  output logic [DW-1:0] o_rdata,
  output logic [AW-1:0] o_dm_address,
  output logic [DW-1:0] o_dm_writedata,
  output logic          o_dm_memread,
  output logic          o_dm_memwrite,
  input  logic [DW-1:0] i_dm_readdata
);

  state_e        r_state;
  logic [1:0]    r_lane;
  logic [1:0]    r_size;
  logic          r_sext;
  logic [DW-1:0] r_wdata;
  logic          r_done;
  logic          r_err;
  logic [DW-1:0] r_rdata;
  logic [AW-1:0] r_dm_address;
  logic [DW-1:0] r_dm_writedata;
  logic          r_dm_memread;
  logic          r_dm_memwrite;

  logic [DW-1:0] w_ld_data;
  logic [DW-1:0] w_st_word;
  logic          w_bad;

  assign w_bad = access_illegal(i_size, i_addr[1:0]);

  mem_lane_align u_lane_align (
    .i_word  (i_dm_readdata),
    .i_wdata (r_wdata),
    .i_lane  (r_lane),
    .i_size  (r_size),
    .i_sext  (r_sext),
    .o_rdata (w_ld_data),
    .o_wword (w_st_word)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= StIdle;
      r_lane         <= '0;
      r_size         <= '0;
      r_sext         <= 1'b0;
      r_wdata        <= '0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_rdata        <= '0;
      r_dm_address   <= '0;
      r_dm_writedata <= '0;
      r_dm_memread   <= 1'b0;
      r_dm_memwrite  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_req) begin
            r_lane       <= i_addr[1:0];
            r_size       <= i_size;
            r_sext       <= i_sext;
            r_wdata      <= i_wdata;
            r_dm_address <= {2'b00, i_addr[AW-1:2]};
            if (w_bad) begin
              // Rejected: complete next cycle, memory never touched
              r_state <= StDone;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
              r_rdata <= '0;
            end else if (!i_we) begin
              r_state      <= StRd;
              r_dm_memread <= 1'b1;
            end else if (i_size == SZ_WORD) begin
              r_state        <= StWr;
              r_dm_memwrite  <= 1'b1;
              r_dm_writedata <= i_wdata;
            end else begin
              r_state      <= StRmwRd;
              r_dm_memread <= 1'b1;
            end
          end
        end
        StRd: begin
          r_dm_memread <= 1'b0;
          r_rdata      <= w_ld_data;
          r_err        <= 1'b0;
          r_done       <= 1'b1;
          r_state      <= StDone;
        end
        StWr: begin
          r_dm_memwrite <= 1'b0;
          r_rdata       <= '0;
          r_err         <= 1'b0;
          r_done        <= 1'b1;
          r_state       <= StDone;
        end
        StRmwRd: begin
          // The write-data register doubles as the merge buffer: the old word
          // with the target lane(s) replaced is captured straight into it.
          r_dm_memread   <= 1'b0;
          r_dm_writedata <= w_st_word;
          r_dm_memwrite  <= 1'b1;
          r_state        <= StRmwWr;
        end
        StRmwWr: begin
          r_dm_memwrite <= 1'b0;
          r_rdata       <= '0;
          r_err         <= 1'b0;
          r_done        <= 1'b1;
          r_state       <= StDone;
        end
        StDone: begin
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_dm_memread  <= 1'b0;
          r_dm_memwrite <= 1'b0;
          r_done        <= 1'b0;
          r_state       <= StIdle;
        end
      endcase
    end
  end

  assign o_ready        = (r_state == StIdle);
  assign o_done         = r_done;
  assign o_err          = r_err;
  assign o_rdata        = r_rdata;
  assign o_dm_address   = r_dm_address;
  assign o_dm_writedata = r_dm_writedata;
  assign o_dm_memread   = r_dm_memread;
  assign o_dm_memwrite  = r_dm_memwrite;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a 16-word data memory (address bits 3:0) sits
// behind the DUT, and a separate reference copy of that memory is updated
// with plain arithmetic from the load/store rules.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        ready;
  logic        we;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] dm_address;
  logic [31:0] dm_writedata;
  logic        dm_memread;
  logic        dm_memwrite;
  logic [31:0] dm_readdata;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] dmem    [16];
  logic [31:0] ref_mem [16];
  logic        pl_en;
  logic [3:0]  pl_idx;
  logic [31:0] pl_val;

  always #5 clk = ~clk;

  mem_access_ctrl #(.AW(32), .DW(32)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req          (req),
    .o_ready        (ready),
    .i_we           (we),
    .i_size         (size),
    .i_sext         (sext),
    .i_addr         (addr),
    .i_wdata        (wdata),
    .o_done         (done),
    .o_err          (err),
    .o_rdata        (rdata),
    .o_dm_address   (dm_address),
    .o_dm_writedata (dm_writedata),
    .o_dm_memread   (dm_memread),
    .o_dm_memwrite  (dm_memwrite),
    .i_dm_readdata  (dm_readdata)
  );

  assign dm_readdata = dmem[dm_address[3:0]];

  always @(posedge clk) begin
    if (pl_en) dmem[pl_idx] <= pl_val;
    else if (dm_memwrite) dmem[dm_address[3:0]] <= dm_writedata;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input int i, input logic [31:0] v);
    ref_mem[i[3:0]] = v;
    pl_idx = i[3:0];
    pl_val = v;
    pl_en  = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  function automatic bit ref_illegal(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] ref_mask(input logic [1:0] sz);
    return (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                           input logic sx);
    int unsigned v;
    v = (ref_mem[a[5:2]] >> (8 * a[1:0])) & ref_mask(sz);
    if (sx && sz == 2'd0 && v >= 128) v = v - 256;
    if (sx && sz == 2'd1 && v >= 32768) v = v - 65536;
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] a, input logic [1:0] sz,
                                            input logic [31:0] d);
    int unsigned sh;
    sh = 8 * a[1:0];
    return (ref_mem[a[5:2]] & ~(ref_mask(sz) << sh)) | ((d & ref_mask(sz)) << sh);
  endfunction

  // Issue one request from just after a falling edge and check it end to end
  task automatic run_access(input string tag, input logic iwe, input logic [1:0] isz,
                            input logic isext, input logic [31:0] iaddr, input logic [31:0] iwd);
    bit          exp_err;
    logic [31:0] exp_rd;
    int          exp_lat, exp_nrd, exp_nwr;
    int          lat, nrd, nwr, nbad, nboth;
    bit          got_done;
    logic        got_err;
    logic [31:0] got_rd;

    exp_err = ref_illegal(isz, iaddr);
    exp_rd  = (exp_err || iwe) ? 32'h0 : ref_load(iaddr, isz, isext);
    exp_lat = exp_err ? 1 : (!iwe || isz == 2'd2) ? 2 : 3;
    exp_nrd = (exp_err || (iwe && isz == 2'd2)) ? 0 : 1;
    exp_nwr = (exp_err || !iwe) ? 0 : 1;
    if (!exp_err && iwe) ref_mem[iaddr[5:2]] = ref_store(iaddr, isz, iwd);

    we = iwe; size = isz; sext = isext; addr = iaddr; wdata = iwd; req = 1'b1;
    for (int k = 0; k < 10 && !ready; k++) @(negedge clk);
    check_eq({tag, ":ready"}, 32'(ready), 32'd1);
    @(posedge clk);

    lat = 0; nrd = 0; nwr = 0; nbad = 0; nboth = 0; got_done = 0;
    got_err = 1'b0; got_rd = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) req = 1'b0;
      if (dm_memread) nrd++;
      if (dm_memwrite) nwr++;
      if (dm_memread && dm_memwrite) nboth++;
      if ((dm_memread || dm_memwrite) && dm_address !== (iaddr >> 2)) nbad++;
      if (done) begin
        lat = c; got_done = 1; got_err = err; got_rd = rdata;
        break;
      end
    end
    if (!got_done) begin
      check_eq({tag, ":timeout"}, 32'd0, 32'd1);
    end else begin
      check_eq({tag, ":lat"}, lat, exp_lat);
      check_eq({tag, ":err"}, 32'(got_err), 32'(exp_err));
      check_eq({tag, ":rdata"}, got_rd, exp_rd);
      check_eq({tag, ":nrd"}, nrd, exp_nrd);
      check_eq({tag, ":nwr"}, nwr, exp_nwr);
      check_eq({tag, ":both"}, nboth, 0);
      check_eq({tag, ":addr"}, nbad, 0);
    end
    @(negedge clk);
    check_eq({tag, ":post"}, 32'({done, ready}), 32'b01);
    check_eq({tag, ":mem"}, dmem[iaddr[5:2]], ref_mem[iaddr[5:2]]);
  endtask

  initial begin
    logic [31:0] ra;
    logic [1:0]  rs;
    int          r;

    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0; sext = 1'b0;
    addr = '0; wdata = '0; pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    repeat (2) @(negedge clk);
    check_eq("rst:ctl", 32'({ready, done, err, dm_memread, dm_memwrite}), 32'b10000);
    check_eq("rst:rdata", rdata, 32'h0);
    check_eq("rst:addr", dm_address, 32'h0);
    check_eq("rst:wdata", dm_writedata, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) preload(i, $urandom);

    // Directed cases
    preload(1, 32'h1122_3344);
    preload(2, 32'hF0E0_D0C0);
    run_access("lw4", 1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    run_access("lb9", 1'b0, 2'd0, 1'b1, 32'h9, 32'h0);
    run_access("lbu9", 1'b0, 2'd0, 1'b0, 32'h9, 32'h0);
    run_access("lhA", 1'b0, 2'd1, 1'b1, 32'hA, 32'h0);
    run_access("sh6", 1'b1, 2'd1, 1'b0, 32'h6, 32'h0000_BEEF);
    check_eq("sh6:word", dmem[1], 32'hBEEF_3344);
    run_access("sb4", 1'b1, 2'd0, 1'b0, 32'h4, 32'h0000_00AA);
    check_eq("sb4:word", dmem[1], 32'hBEEF_33AA);
    run_access("sw3", 1'b1, 2'd2, 1'b0, 32'h3, 32'h1234_5678);
    run_access("lh5", 1'b0, 2'd1, 1'b1, 32'h5, 32'h0);
    run_access("sz11", 1'b1, 2'd3, 1'b0, 32'h8, 32'hFFFF_FFFF);
    run_access("sw0", 1'b1, 2'd2, 1'b0, 32'h0, 32'hCAFE_F00D);
    run_access("wrap", 1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0);

    // Held request: the second one must wait for the first to complete
    we = 1'b0; size = 2'd2; sext = 1'b0; addr = 32'h4; wdata = '0; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    addr = 32'h8; size = 2'd0;
    check_eq("hs:a_rd", 32'({dm_memread, ready}), 32'b10);
    check_eq("hs:a_addr", dm_address, 32'h1);
    @(negedge clk);
    check_eq("hs:a_done", 32'({done, ready, dm_memread, dm_memwrite}), 32'b1000);
    check_eq("hs:a_rdata", rdata, ref_mem[1]);
    run_access("hs_b", 1'b0, 2'd0, 1'b0, 32'h8, 32'h0);

    // Reset asserted while the write half of a read-modify-write is pending
    preload(3, 32'h5566_7788);
    we = 1'b1; size = 2'd0; sext = 1'b0; addr = 32'hD; wdata = 32'hAA; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check_eq("rmwrst:rd", 32'(dm_memread), 32'd1);
    @(negedge clk);
    check_eq("rmwrst:wr", 32'(dm_memwrite), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_eq("rmwrst:drop", 32'({dm_memwrite, ready, done}), 32'b010);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rmwrst:mem", dmem[3], 32'h5566_7788);
    check_eq("rmwrst:idle", 32'({ready, done}), 32'b10);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      r  = $urandom_range(0, 9);
      rs = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      ra = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (rs == 2'd1) ra[0] = 1'b0;
        if (rs == 2'd2) ra[1:0] = 2'b00;
      end
      run_access("rnd", 1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ra, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
